// File: rtl/tile_match_pkg.sv
// Shared types and helpers for the tile-matching turn judge.
package tile_match_pkg;

  // Tile code width used when the top level is not overridden.
  localparam int TILE_W_DEFAULT = 4;

  // Judge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_JUDGE     = 2'd2
  } state_t;

  // Width of a player index. It is never narrower than one bit, so a
  // single-player game still has a legal port.
  function automatic int pid_width(input int players);
    return (players <= 2) ? 1 : $clog2(players);
  endfunction

endpackage

// File: rtl/player_rotator.sv
// Owns the active player index and that player's consecutive-match streak.
module player_rotator
  import tile_match_pkg::*;
#(
  parameter int PLAYERS  = 2,
  parameter int STREAK_W = 4,
  parameter int PID_W    = pid_width(PLAYERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,       // synchronous restart
  input  logic                advance,     // miss: hand the turn on
  input  logic                hit,         // match: extend the streak
  output logic [PID_W-1:0]    cur_player,
  output logic [STREAK_W-1:0] streak,
  output logic [STREAK_W-1:0] streak_inc   // value the streak takes on a hit
);

  localparam logic [STREAK_W-1:0] STREAK_MAX  = '1;
  localparam logic [PID_W-1:0]    LAST_PLAYER = PID_W'(PLAYERS - 1);

  // Saturating increment; the win latch compares against this value.
  assign streak_inc = (streak == STREAK_MAX) ? streak : streak + 1'b1;

  // Player and streak registers: a hit extends the streak, a miss clears it
  // and passes the turn, wrapping after the last player.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      cur_player <= '0;
      streak     <= '0;
    end else if (clear) begin
      cur_player <= '0;
      streak     <= '0;
    end else if (hit) begin
      streak <= streak_inc;
    end else if (advance) begin
      streak     <= '0;
      cur_player <= (cur_player == LAST_PLAYER) ? '0 : cur_player + 1'b1;
    end
  end

endmodule

// File: rtl/tile_match_judge.sv
// Turn judge: captures centre then edge tile, compares them, reports a
// one-cycle verdict and keeps turn, streak and win state.
module tile_match_judge
  import tile_match_pkg::*;
#(
  parameter int TILE_W     = TILE_W_DEFAULT,
  parameter int PLAYERS    = 2,
  parameter int WIN_STREAK = 12,
  parameter int STREAK_W   = 4,
  parameter int PID_W      = pid_width(PLAYERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  input  logic                center_valid,
  input  logic [TILE_W-1:0]   center_tile,
  output logic                center_ready,
  input  logic                edge_valid,
  input  logic [TILE_W-1:0]   edge_tile,
  output logic                edge_ready,
  input  logic                turn_abort,
  output logic                result_valid,
  output logic                result_match,
  output logic [PID_W-1:0]    result_player,
  output logic [PID_W-1:0]    cur_player,
  output logic [STREAK_W-1:0] streak,
  output logic                game_over,
  output logic [PID_W-1:0]    winner
);

  localparam logic [STREAK_W-1:0] WIN_VAL = STREAK_W'(WIN_STREAK);

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   center_q, edge_q;
  logic [STREAK_W-1:0] streak_inc;
  logic                tiles_equal, judge_commit, hit, advance;

  // Outputs decode only from registers, so no input reaches an output
  // combinationally.
  assign center_ready  = (state_q == ST_IDLE) && !game_over;
  assign edge_ready    = (state_q == ST_WAIT_EDGE);
  assign tiles_equal   = (center_q == edge_q);
  assign result_valid  = (state_q == ST_JUDGE);
  assign result_match  = result_valid && tiles_equal;
  assign result_player = cur_player;

  // The verdict scores at the edge ending JUDGE unless the turn is aborted
  // or the game restarted in that cycle.
  assign judge_commit = (state_q == ST_JUDGE) && !turn_abort && !new_game;
  assign hit          = judge_commit && tiles_equal;
  assign advance      = judge_commit && !tiles_equal;

  // Next-state logic: centre, then edge, then a single judge cycle; abort
  // overrides any handshake.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches
    // on paths that do not change state.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (center_valid && center_ready) state_d = ST_WAIT_EDGE;
      ST_WAIT_EDGE: if (edge_valid) state_d = ST_JUDGE;
      ST_JUDGE:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (turn_abort) state_d = ST_IDLE;
  end

  // State register; new_game restarts like reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= ST_IDLE;
    else if (new_game) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  // Tile capture registers, loaded on their accepting handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops, not a memory array, so resetting them
    // costs nothing and keeps the compare deterministic after restart.
    if (!rst_n) begin
      center_q <= '0;
      edge_q   <= '0;
    end else if (new_game) begin
      center_q <= '0;
      edge_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && center_valid && center_ready)
        center_q <= center_tile;
      if (state_q == ST_WAIT_EDGE && edge_valid && !turn_abort)
        edge_q <= edge_tile;
    end
  end

  // Sticky win latch: the first hit that brings the streak to WIN_STREAK
  // records the winner until restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_over <= 1'b0;
      winner    <= '0;
    end else if (new_game) begin
      game_over <= 1'b0;
      winner    <= '0;
    end else if (hit && !game_over && streak_inc == WIN_VAL) begin
      game_over <= 1'b1;
      winner    <= cur_player;
    end
  end

  player_rotator #(
    .PLAYERS  (PLAYERS),
    .STREAK_W (STREAK_W),
    .PID_W    (PID_W)
  ) u_rotator (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (new_game),
    .advance    (advance),
    .hit        (hit),
    .cur_player (cur_player),
    .streak     (streak),
    .streak_inc (streak_inc)
  );

endmodule

// File: tb/tb_tile_match_judge.sv
// Self-checking bench: a per-cycle vector table plus hand-written sequences
// for win, saturation, abort and mid-turn reset. Three instances share the
// same stimulus with different parameters.
module tb_tile_match_judge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       cv = 1'b0, ev = 1'b0, ab = 1'b0;
  logic [3:0] ct = '0, et = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut_a: defaults (2 players, win at 12).
  logic       a_cr, a_er, a_rv, a_rm, a_go;
  logic [0:0] a_rp, a_cp, a_win;
  logic [3:0] a_st;
  tile_match_judge dut_a (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .center_valid(cv), .center_tile(ct), .center_ready(a_cr),
    .edge_valid(ev), .edge_tile(et), .edge_ready(a_er),
    .turn_abort(ab), .result_valid(a_rv), .result_match(a_rm),
    .result_player(a_rp), .cur_player(a_cp), .streak(a_st),
    .game_over(a_go), .winner(a_win)
  );

  // dut_w: 2 players, win after three matches.
  logic       w_cr, w_er, w_rv, w_rm, w_go;
  logic [0:0] w_rp, w_cp, w_win;
  logic [3:0] w_st;
  tile_match_judge #(.WIN_STREAK(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .center_valid(cv), .center_tile(ct), .center_ready(w_cr),
    .edge_valid(ev), .edge_tile(et), .edge_ready(w_er),
    .turn_abort(ab), .result_valid(w_rv), .result_match(w_rm),
    .result_player(w_rp), .cur_player(w_cp), .streak(w_st),
    .game_over(w_go), .winner(w_win)
  );

  // dut_s: 3 players, 2-bit streak saturating at 3, win at 3.
  logic       s_cr, s_er, s_rv, s_rm, s_go;
  logic [1:0] s_rp, s_cp, s_win;
  logic [1:0] s_st;
  tile_match_judge #(.PLAYERS(3), .STREAK_W(2), .WIN_STREAK(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .center_valid(cv), .center_tile(ct), .center_ready(s_cr),
    .edge_valid(ev), .edge_tile(et), .edge_ready(s_er),
    .turn_abort(ab), .result_valid(s_rv), .result_match(s_rm),
    .result_player(s_rp), .cur_player(s_cp), .streak(s_st),
    .game_over(s_go), .winner(s_win)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle for dut_a: inputs driven for that cycle and the
  // outputs expected during it.
  typedef struct {
    logic       cv;
    logic [3:0] ct;
    logic       ev;
    logic [3:0] et;
    logic       ab;
    logic       rv;
    logic       rm;
    logic       rp;
    logic       cp;
    logic [3:0] st;
    logic       cr;
    logic       er;
  } vec_t;

  vec_t vecs[20];

  task automatic pulse_new_game();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
  endtask

  // Offers a centre then an edge; returns at the falling edge of the cycle
  // in which the verdict is expected.
  task automatic run_turn(input logic [3:0] c, input logic [3:0] e);
    @(negedge clk) begin cv = 1'b1; ct = c; end
    @(negedge clk) begin cv = 1'b0; ev = 1'b1; et = e; end
    @(negedge clk) ev = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    //                cv ct    ev et    ab  rv rm rp cp st    cr er
    vecs[0]  = '{1'b1, 4'h5, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd0, 1, 0};
    vecs[1]  = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 0, 0, 0, 0, 4'd0, 0, 1};
    vecs[2]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1, 0, 0, 4'd0, 0, 0};
    vecs[3]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd1, 1, 0};
    vecs[4]  = '{1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 0, 0, 0, 0, 4'd1, 0, 1};
    vecs[5]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1, 0, 0, 0, 4'd1, 0, 0};
    vecs[6]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 0, 0, 1, 1, 4'd0, 1, 0};
    vecs[7]  = '{1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 0, 0, 1, 1, 4'd0, 0, 1};
    vecs[8]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1, 0, 1, 1, 4'd0, 0, 0};
    // centre and edge together in IDLE: only the centre (7) is taken
    vecs[9]  = '{1'b1, 4'h7, 1'b1, 4'h2, 1'b0, 0, 0, 0, 0, 4'd0, 1, 0};
    vecs[10] = '{1'b0, 4'h0, 1'b1, 4'h7, 1'b0, 0, 0, 0, 0, 4'd0, 0, 1};
    vecs[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1, 0, 0, 4'd0, 0, 0};
    // abort in WAIT_EDGE wins over the edge handshake
    vecs[12] = '{1'b1, 4'h9, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd1, 1, 0};
    vecs[13] = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 0, 0, 0, 0, 4'd1, 0, 1};
    vecs[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd1, 1, 0};
    // centre offered again while in WAIT_EDGE is ignored
    vecs[15] = '{1'b1, 4'h4, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd1, 1, 0};
    vecs[16] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd1, 0, 1};
    vecs[17] = '{1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 0, 0, 0, 0, 4'd1, 0, 1};
    vecs[18] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1, 1, 0, 0, 4'd1, 0, 0};
    vecs[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 0, 0, 0, 0, 4'd2, 1, 0};

    // Reset, released on a falling edge.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset a game_over", a_go, 0);
    check("reset a winner", a_win, 0);
    check("reset w result_valid", w_rv, 0);
    check("reset s cur_player", s_cp, 0);
    check("reset s center_ready", s_cr, 1);

    // Table: check this cycle's outputs, then drive this cycle's inputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("v%0d result_valid", i), a_rv, vecs[i].rv);
      check($sformatf("v%0d result_match", i), a_rm, vecs[i].rm);
      check($sformatf("v%0d result_player", i), a_rp, vecs[i].rp);
      check($sformatf("v%0d cur_player", i), a_cp, vecs[i].cp);
      check($sformatf("v%0d streak", i), a_st, vecs[i].st);
      check($sformatf("v%0d center_ready", i), a_cr, vecs[i].cr);
      check($sformatf("v%0d edge_ready", i), a_er, vecs[i].er);
      cv = vecs[i].cv; ct = vecs[i].ct;
      ev = vecs[i].ev; et = vecs[i].et;
      ab = vecs[i].ab;
    end
    cv = 1'b0; ev = 1'b0; ab = 1'b0;

    // The table held two misses: the three-player instance is on player 2.
    check("s cur_player after two misses", s_cp, 2);
    check("w streak after table", w_st, 2);
    run_turn(4'h1, 4'h2);
    @(negedge clk);
    check("s cur_player wraps to 0", s_cp, 0);
    check("a cur_player after miss", a_cp, 1);
    check("w streak cleared by miss", w_st, 0);

    // Three matches for player 0 end the short games.
    pulse_new_game();
    check("new_game a streak", a_st, 0);
    check("new_game a cur_player", a_cp, 0);
    run_turn(4'h5, 4'h5);
    check("win turn1 w result_match", w_rm, 1);
    run_turn(4'h6, 4'h6);
    run_turn(4'h7, 4'h7);
    check("win turn3 w result_valid", w_rv, 1);
    check("win turn3 w game_over not yet", w_go, 0);
    @(negedge clk);
    check("win w game_over", w_go, 1);
    check("win w winner", w_win, 0);
    check("win w center_ready", w_cr, 0);
    check("win w streak", w_st, 3);
    check("win s game_over", s_go, 1);
    check("win s streak", s_st, 3);
    check("win a game_over", a_go, 0);
    check("win a center_ready", a_cr, 1);

    // A fourth offer is refused once the game is over.
    run_turn(4'h1, 4'h1);
    check("over s result_valid", s_rv, 0);
    check("over s edge_ready", s_er, 0);
    check("over a result_valid", a_rv, 1);
    @(negedge clk);
    check("over s streak saturated", s_st, 3);
    check("over s game_over sticky", s_go, 1);
    check("over w game_over sticky", w_go, 1);
    check("over a streak", a_st, 4);

    // Restart returns every output to its reset value.
    pulse_new_game();
    check("restart w result_valid", w_rv, 0);
    check("restart w result_match", w_rm, 0);
    check("restart w result_player", w_rp, 0);
    check("restart w cur_player", w_cp, 0);
    check("restart w streak", w_st, 0);
    check("restart w game_over", w_go, 0);
    check("restart w winner", w_win, 0);
    check("restart w center_ready", w_cr, 1);
    check("restart w edge_ready", w_er, 0);
    check("restart s game_over", s_go, 0);

    // Abort during JUDGE: a miss is not scored, player keeps the turn.
    run_turn(4'h3, 4'h3);
    @(negedge clk);
    check("pre-abort a streak", a_st, 1);
    run_turn(4'h2, 4'h9);
    ab = 1'b1;
    @(negedge clk) ab = 1'b0;
    check("abort judge a streak", a_st, 1);
    check("abort judge a cur_player", a_cp, 0);
    check("abort judge a center_ready", a_cr, 1);

    // Reset asserted just after the edge is accepted: no verdict appears.
    @(negedge clk) begin cv = 1'b1; ct = 4'h8; end
    @(negedge clk) begin cv = 1'b0; ev = 1'b1; et = 4'h8; end
    @(posedge clk);
    #1 rst_n = 1'b0;
    ev = 1'b0;
    @(negedge clk);
    check("reset judge a result_valid", a_rv, 0);
    check("reset judge a streak", a_st, 0);
    check("reset judge a cur_player", a_cp, 0);
    check("reset judge a center_ready", a_cr, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset a result_valid", a_rv, 0);
    check("after reset a edge_ready", a_er, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
